fft_out_reorder: RTL and testbench

- Sits directly downstream of the fft core; consumes its butterfly pair stream (o_valid_out, o_data_a_*, o_data_b_*).
- Bit-reversed pair stream in; natural-order stream out, one complex sample per cycle, with frame markers.
- Two-bank ping-pong buffer, so frame f is read out while frame f+1 is written.
- Q16.16 data in and out, unmodified unless the optional feature is compiled in.

---
 rtl/fft_out_reorder.sv | 232 +++++++++++++++++++++++
 tb/tb_fft_out_reorder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// fft_out_reorder
//   Converts the fft core's bit-reversed butterfly pair stream into a
//   natural-order stream of one complex sample per cycle, with frame markers.
//   Two banks are used as a ping-pong buffer: one frame is read out while the
//   next one is written. Each bank holds a LO half (bins 0..N/2-1) and a HI
//   half (bins N/2..N-1), so both elements of a pair are written in one cycle.
//
//   Optional build macro: FFTR_NORM_EN
//     defined   -> output words are arithmetically right-shifted by NORM_SHIFT
//     undefined -> output words pass through bit-exact
//
// Ports
//   i_clk          system clock
//   i_reset        asynchronous reset, active low
//   i_valid_in     pair valid
//   i_data_a_*     pair element A (bin bitrev(2k)), real/imag
//   i_data_b_*     pair element B (bin bitrev(2k)+N/2), real/imag
//   o_valid_out    output sample valid
//   o_data_*       natural-order bin, real/imag
//   o_index        bin index of the current output sample
//   o_sof / o_eof  high with index 0 / index N-1
//   o_overflow     sticky, set when a whole frame had to be dropped
module fft_out_reorder #(
    parameter int unsigned N          = 1024,
    parameter int unsigned DW         = 32,
    parameter int unsigned NORM_SHIFT = 10
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid_in,
    input  logic [DW-1:0]        i_data_a_real,
    input  logic [DW-1:0]        i_data_a_imag,
    input  logic [DW-1:0]        i_data_b_real,
    input  logic [DW-1:0]        i_data_b_imag,
    output logic                 o_valid_out,
    output logic [DW-1:0]        o_data_real,
    output logic [DW-1:0]        o_data_imag,
    output logic [$clog2(N)-1:0] o_index,
    output logic                 o_sof,
    output logic                 o_eof,
    output logic                 o_overflow
);

    localparam int unsigned AW   = $clog2(N);
    localparam int unsigned HW   = AW - 1;
    localparam int unsigned HALF = N / 2;
    localparam logic [AW-1:0] LAST_IDX  = AW'(N - 1);
    localparam logic [HW-1:0] LAST_PAIR = HW'(HALF - 1);

`ifdef FFTR_NORM_EN
    localparam bit NORM_ON = 1'b1;
`else
    localparam bit NORM_ON = 1'b0;
`endif
    // A zero shift is an exact pass-through.
    localparam int unsigned SHIFT_EFF = NORM_ON ? NORM_SHIFT : 0;

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL,
        BANK_READING
    } bank_state_t;

    bank_state_t bank_state [2];

    // Write side
    logic [HW-1:0] wptr;
    logic          w_bank;
    logic          w_drop;

    // Read side
    logic          r_active;
    logic          r_bank;
    logic [AW-1:0] rptr;

    // Storage: address = {bank, half-address}; word = {real, imag}
    logic [2*DW-1:0] lo_mem [0:2*HALF-1];
    logic [2*DW-1:0] hi_mem [0:2*HALF-1];

    // Pipeline stage 1 (registered RAM read)
    logic            s1_valid;
    logic [AW-1:0]   s1_idx;
    logic [2*DW-1:0] s1_lo;
    logic [2*DW-1:0] s1_hi;

    function automatic logic [HW-1:0] bitrev_half(input logic [HW-1:0] v);
        logic [HW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < HW; i++) begin
            r[i] = v[HW-1-i];
        end
        return r;
    endfunction

    logic          frame_start;
    logic          free_avail;
    logic          free_bank;
    logic          wr_bank;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          full0;
    logic          full1;
    logic          full_bank;
    logic          rd_go;
    logic          rd_bank;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] rd_addr;

    always_comb begin
        frame_start = i_valid_in && (wptr == '0);
        free_avail  = (bank_state[0] == BANK_FREE) || (bank_state[1] == BANK_FREE);
        free_bank   = (bank_state[0] == BANK_FREE) ? 1'b0 : 1'b1;
        wr_bank     = frame_start ? free_bank : w_bank;
        // The bank/drop decision of a frame is made on its first pair and held.
        wr_en       = i_valid_in && (frame_start ? free_avail : !w_drop);
        wr_addr     = {wr_bank, bitrev_half(wptr)};

        full0       = (bank_state[0] == BANK_FULL);
        full1       = (bank_state[1] == BANK_FULL);
        // With both banks full the one not read last is the older frame.
        full_bank   = (full0 && full1) ? ~r_bank : (full0 ? 1'b0 : 1'b1);
        // An idle reader starts a FULL bank at index 0 in the same cycle, which
        // removes the bubble between back-to-back frames.
        rd_go       = r_active || full0 || full1;
        rd_bank     = r_active ? r_bank : full_bank;
        rd_idx      = r_active ? rptr : '0;
        rd_addr     = {rd_bank, rd_idx[HW-1:0]};
    end

    // RAM arrays: no reset, contents are don't-care after reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            lo_mem[wr_addr] <= {i_data_a_real, i_data_a_imag};
            hi_mem[wr_addr] <= {i_data_b_real, i_data_b_imag};
        end
        if (rd_go) begin
            s1_lo <= lo_mem[rd_addr];
            s1_hi <= hi_mem[rd_addr];
        end
    end

    logic [2*DW-1:0] sel_word;
    logic [DW-1:0]   sel_re;
    logic [DW-1:0]   sel_im;

    always_comb begin
        sel_word = s1_idx[AW-1] ? s1_hi : s1_lo;
        sel_re   = sel_word[2*DW-1:DW];
        sel_im   = sel_word[DW-1:0];
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wptr        <= '0;
            w_bank      <= 1'b0;
            w_drop      <= 1'b0;
            r_active    <= 1'b0;
            r_bank      <= 1'b0;
            rptr        <= '0;
            s1_valid    <= 1'b0;
            s1_idx      <= '0;
            o_valid_out <= 1'b0;
            o_data_real <= '0;
            o_data_imag <= '0;
            o_index     <= '0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_overflow  <= 1'b0;
            for (int unsigned b = 0; b < 2; b++) begin
                bank_state[b] <= BANK_FREE;
            end
        end else begin
            // Writer
            if (i_valid_in) begin
                wptr <= wptr + 1'b1;
                if (frame_start) begin
                    w_bank <= free_bank;
                    w_drop <= !free_avail;
                    if (!free_avail) begin
                        o_overflow <= 1'b1;
                    end
                end
            end

            // Bank states: writer and reader never touch the same bank at once.
            for (int unsigned b = 0; b < 2; b++) begin
                if (wr_en && (wr_bank == 1'(b))) begin
                    if (frame_start) begin
                        bank_state[b] <= BANK_FILLING;
                    end else if (wptr == LAST_PAIR) begin
                        bank_state[b] <= BANK_FULL;
                    end
                end
                if (rd_go && (rd_bank == 1'(b))) begin
                    bank_state[b] <= (rd_idx == LAST_IDX) ? BANK_FREE : BANK_READING;
                end
            end

            // Reader
            if (rd_go) begin
                r_bank <= rd_bank;
                if (rd_idx == LAST_IDX) begin
                    r_active <= 1'b0;
                    rptr     <= '0;
                end else begin
                    r_active <= 1'b1;
                    rptr     <= rd_idx + 1'b1;
                end
            end
            s1_valid <= rd_go;
            s1_idx   <= rd_idx;

            // Output register
            o_valid_out <= s1_valid;
            if (s1_valid) begin
                o_data_real <= DW'($signed(sel_re) >>> SHIFT_EFF);
                o_data_imag <= DW'($signed(sel_im) >>> SHIFT_EFF);
                o_index     <= s1_idx;
                o_sof       <= (s1_idx == '0);
                o_eof       <= (s1_idx == LAST_IDX);
            end else begin
                o_data_real <= '0;
                o_data_imag <= '0;
                o_index     <= '0;
                o_sof       <= 1'b0;
                o_eof       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder
//   Scoreboard bench for fft_out_reorder (N=1024, DW=32). Expected natural
//   order samples are queued when a frame is driven and popped as the DUT
//   emits them. Honours FFTR_NORM_EN for the expected output scaling.
module tb_fft_out_reorder;

    localparam int N    = 1024;
    localparam int DW   = 32;
    localparam int HALF = N / 2;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_valid_in = 1'b0;
    logic [31:0]   i_data_a_real = '0;
    logic [31:0]   i_data_a_imag = '0;
    logic [31:0]   i_data_b_real = '0;
    logic [31:0]   i_data_b_imag = '0;
    logic          o_valid_out;
    logic [31:0]   o_data_real;
    logic [31:0]   o_data_imag;
    logic [9:0]    o_index;
    logic          o_sof;
    logic          o_eof;
    logic          o_overflow;

    always #10 i_clk = ~i_clk;

    fft_out_reorder #(.N(N), .DW(DW), .NORM_SHIFT(10)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_valid_in    (i_valid_in),
        .i_data_a_real (i_data_a_real),
        .i_data_a_imag (i_data_a_imag),
        .i_data_b_real (i_data_b_real),
        .i_data_b_imag (i_data_b_imag),
        .o_valid_out   (o_valid_out),
        .o_data_real   (o_data_real),
        .o_data_imag   (o_data_imag),
        .o_index       (o_index),
        .o_sof         (o_sof),
        .o_eof         (o_eof),
        .o_overflow    (o_overflow)
    );

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
        logic [9:0]  idx;
    } exp_t;

    exp_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [9:0] brev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[9-i];
        return r;
    endfunction

    // pat 0: ramp, real = bin | tag<<16, imag = ~real
    // pat 1: normalisation pattern, alternating +1.0 / -1.0 in Q16.16
    function automatic logic [31:0] bin_re(input int pat, input int n, input int tag);
        if (pat == 1) return n[0] ? 32'hFFFF_0000 : 32'h0001_0000;
        return 32'(n) | (32'(tag) << 16);
    endfunction

    function automatic logic [31:0] bin_im(input int pat, input int n, input int tag);
        if (pat == 1) return 32'(n) << 16;
        return ~bin_re(pat, n, tag);
    endfunction

    function automatic logic [31:0] norm(input logic [31:0] v);
`ifdef FFTR_NORM_EN
        return 32'($signed(v) >>> 10);
`else
        return v;
`endif
    endfunction

    // Monitor
    int run_len = 0;
    int max_run = 0;
    int ovf_cyc = -1;
    always @(negedge i_clk) begin
        exp_t e;
        if (i_reset) begin
            if (o_overflow && ovf_cyc < 0) ovf_cyc = cyc;
            if (o_valid_out) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 80'({o_index, o_data_real}), 80'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("sample",
                          {o_data_real, o_data_imag, o_index, o_sof, o_eof, 4'b0},
                          {e.re, e.im, e.idx, e.idx == 10'd0, e.idx == 10'd1023, 4'b0});
                end
            end else begin
                run_len = 0;
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ar, input logic [31:0] ai,
                         input logic [31:0] br, input logic [31:0] bi);
        @(posedge i_clk);
        #1;
        i_valid_in    = v;
        i_data_a_real = ar;
        i_data_a_imag = ai;
        i_data_b_real = br;
        i_data_b_imag = bi;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0);
    endtask

    task automatic send_frame(input int pat, input int tag, input bit gappy, input bit keep,
                              output int first_cyc, output int last_cyc);
        logic [9:0] a;
        logic [9:0] b;
        first_cyc = 0;
        last_cyc  = 0;
        if (keep) begin
            for (int n = 0; n < N; n++) begin
                sb_q.push_back('{norm(bin_re(pat, n, tag)), norm(bin_im(pat, n, tag)), 10'(n)});
            end
        end
        for (int k = 0; k < HALF; k++) begin
            a = brev10(10'(2 * k));
            b = a + 10'd512;
            drive(1'b1, bin_re(pat, int'(a), tag), bin_im(pat, int'(a), tag),
                        bin_re(pat, int'(b), tag), bin_im(pat, int'(b), tag));
            if (k == 0) first_cyc = cyc;
            last_cyc = cyc;
            if (gappy) idle();
        end
    endtask

    // Expects the first output 2 cycles after the edge that writes the last pair.
    task automatic wait_first_valid(input int last_cyc);
        int t = 0;
        while (!o_valid_out && t < 20) begin
            @(negedge i_clk);
            t++;
        end
        check("first_valid_latency", 80'(cyc - last_cyc), 80'(3));
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb_q.size() != 0 || o_valid_out) && t < 6000) begin
            @(negedge i_clk);
            t++;
        end
        check("drain_left", 80'(sb_q.size()), 80'(0));
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        int l;
        int f3;
        bit hit;

        #5 i_reset = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset_outputs",
              80'({o_valid_out, o_data_real, o_data_imag, o_index, o_sof, o_eof, o_overflow}), 80'(0));
        i_reset = 1'b1;

        // Index ramp, no gaps
        send_frame(0, 0, 1'b0, 1'b1, f, l);
        idle();
        wait_first_valid(l);
        wait_drain();

        // Same frame, valid toggling every cycle
        send_frame(0, 0, 1'b1, 1'b1, f, l);
        idle();
        wait_first_valid(l);
        wait_drain();

        // Back-to-back frames, second starting 1024 cycles after the first
        max_run = 0;
        send_frame(0, 1, 1'b0, 1'b1, f, l);
        repeat (HALF) idle();
        send_frame(0, 2, 1'b0, 1'b1, f, l);
        idle();
        wait_drain();
        check("b2b_run_len", 80'(max_run), 80'(2 * N));
        check("b2b_overflow", 80'(o_overflow), 80'(0));

        // Three contiguous frames: the third is dropped
        max_run = 0;
        send_frame(0, 3, 1'b0, 1'b1, f, l);
        send_frame(0, 4, 1'b0, 1'b1, f, l);
        send_frame(0, 5, 1'b0, 1'b0, f3, l);
        idle();
        wait_drain();
        repeat (20) @(negedge i_clk);
        check("ovf_rise_cycle", 80'(ovf_cyc), 80'(f3 + 1));
        check("ovf_sticky", 80'(o_overflow), 80'(1));
        check("ovf_run_len", 80'(max_run), 80'(2 * N));

        // Reset in the middle of a read
        send_frame(0, 6, 1'b0, 1'b1, f, l);
        idle();
        hit = 1'b0;
        for (int t = 0; t < 3000 && !hit; t++) begin
            @(negedge i_clk);
            if (o_valid_out && o_index == 10'd300) hit = 1'b1;
        end
        check("reach_index_300", 80'(hit), 80'(1));
        #2 i_reset = 1'b0;
        #1;
        check("reset_mid_read",
              80'({o_valid_out, o_data_real, o_data_imag, o_index, o_sof, o_eof, o_overflow}), 80'(0));
        sb_q.delete();
        repeat (3) @(negedge i_clk);
        check("reset_hold_valid", 80'(o_valid_out), 80'(0));
        #2 i_reset = 1'b1;
        send_frame(0, 7, 1'b0, 1'b1, f, l);
        idle();
        wait_first_valid(l);
        wait_drain();
        check("post_reset_overflow", 80'(o_overflow), 80'(0));

        // +1.0 / -1.0 pattern (scaled when normalisation is compiled in)
        send_frame(1, 0, 1'b0, 1'b1, f, l);
        idle();
        wait_first_valid(l);
        wait_drain();

        repeat (10) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
